shift_seq_8b: RTL
=================

Name: shift_seq_8b

Overview:
- Control sequencer that sits directly upstream of the team's 8-bit universal shift register (mode select s[1:0]: 11 load, 10 shift left, 01 shift right, 00 hold).
- On a start request it loads a byte into the register, then issues N left or right shifts with a programmable fill (constant bit or rotate).
- It exposes each shifted-out bit as a serial stream with a valid flag, and returns a one-cycle done pulse when finished.
- It reads the register's Q output back to generate rotate fill bits and serial output.

Parameters:
- WIDTH, 8, data width of the downstream shift register (the spec and tests assume 8).
- CNT_W, 4, width of the shift-count input and the internal counter.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- CLRb  input  1  synchronous active-low reset, sampled on the rising edge of CLK.
- start  input  1  request; accepted only in IDLE.
- dir  input  1  1 = shift left (toward bit 7), 0 = shift right.
- rotate  input  1  1 = fill with the bit leaving the opposite end; 0 = fill with fill_in.
- fill_in  input  1  constant fill bit used when rotate = 0.
- count  input  CNT_W  number of shifts; values above WIDTH are clamped to WIDTH.
- din  input  WIDTH  byte to load.
- q_in  input  WIDTH  Q readback from the shift register.
- s  output  2  mode select to the shift register.
- D  output  WIDTH  parallel load data to the shift register.
- SDL  output  1  serial fill for left shift; enters bit 0.
- SDR  output  1  serial fill for right shift; enters bit 7.
- sout  output  1  bit being shifted out this cycle.
- sout_valid  output  1  qualifies sout.
- busy  output  1  high in LOAD and SHIFT.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset and reset values:
  - CLRb low at a rising edge: state = IDLE; latched din, dir, rotate, fill_in and count cleared to 0; shift counter = 0.
  - Outputs after reset: s = 00, D = 0, SDL = 0, SDR = 0, sout = 0, sout_valid = 0, busy = 0, done = 0.
  - Reset mid-operation aborts immediately. No done pulse is produced. Downstream register contents are left untouched.
- FSM has four states: IDLE, LOAD, SHIFT, DONE. All control outputs are Moore outputs decoded from state. sout, SDL and SDR additionally depend combinationally on q_in.
- IDLE:
  - s = 00.
  - start = 1 at an edge latches din, dir, rotate, fill_in and min(count, WIDTH), then moves to LOAD.
- LOAD:
  - s = 11, D = latched din. The register captures din at the end of this cycle.
  - Next state is SHIFT if the latched count > 0, otherwise DONE.
  - The counter is loaded with the latched count.
- SHIFT:
  - s = 10 when dir = 1, s = 01 when dir = 0.
  - SDL = rotate ? q_in[7] : fill_in. SDR = rotate ? q_in[0] : fill_in.
  - sout = dir ? q_in[7] : q_in[0]. sout_valid = 1.
  - The counter decrements each cycle. Leave for DONE in the cycle the counter reaches 1, so exactly N shift cycles occur.
- DONE:
  - s = 00, done = 1, busy = 0.
  - Always returns to IDLE on the next edge.
- D holds the latched din in every state (0 after reset). SDL and SDR are 0 outside SHIFT.
- start outside IDLE (LOAD, SHIFT or DONE) is ignored and not queued. Changes to the inputs after acceptance have no effect.
- Latency, with start accepted at edge k:
  - LOAD occupies cycle k+1.
  - Shifts occupy cycles k+2 .. k+1+N.
  - done is high in cycle k+2+N.
  - The next start can be accepted at edge k+3+N.
- count = 0 gives load only: done at k+2.
- count ≥ WIDTH gives exactly WIDTH shifts.

Test Plan:
- Left shift, constant fill: din=0xB4, dir=1, rotate=0, fill_in=0, count=3.
  - Required: s sequence 11,10,10,10,00.
  - Required: sout = 1,0,1.
  - Required: register Q = 0xB4, 0x68, 0xD0, 0xA0.
  - Required: done in cycle k+5.
- Right rotate: din=0x81, dir=0, rotate=1, count=1.
  - Required: Q = 0xC0, sout = 1, done at k+3.
- Full left rotate: din=0x5A, dir=1, rotate=1, count=8.
  - Required: sout = 0,1,0,1,1,0,1,0; final Q = 0x5A.
  - Repeat with count=12: identical result (clamp to 8 shifts).
- count=0: din=0x3C.
  - Required: one LOAD cycle (s=11), then done=1 at k+2 with no sout_valid; Q = 0x3C.
- start held high during SHIFT:
  - Required: ignored; exactly one done pulse; the next operation begins only when start is sampled in IDLE.
- CLRb=0 in the second SHIFT cycle of an 8-shift job:
  - Required: next cycle IDLE, s=00, busy=0, D=0, no done pulse.
  - Required: a fresh start is accepted normally afterwards.

Source files
------------

// File: rtl/shift_seq_8b.sv
`default_nettype none
// ============================================================================
//  Module   : shift_seq_8b
//  Purpose  : Control sequencer for an 8-bit universal shift register
//             (s: 11 load, 10 shift left, 01 shift right, 00 hold). On a
//             start request it loads a byte, issues N shifts with constant or
//             rotate fill, streams the shifted-out bits and pulses done.
//  Ports    : CLK, CLRb (sync active-low reset)
//             start, dir, rotate, fill_in, count, din  - job request
//             q_in                                     - register Q readback
//             s, D, SDL, SDR                           - register controls
//             sout, sout_valid                         - serial output stream
//             busy, done                               - status
//  Revision : 1.0 - initial release
// ============================================================================
module shift_seq_8b #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             CLRb,
  input  logic             start,
  input  logic             dir,
  input  logic             rotate,
  input  logic             fill_in,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] q_in,
  output logic [1:0]       s,
  output logic [WIDTH-1:0] D,
  output logic             SDL,
  output logic             SDR,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [CNT_W-1:0] C_WIDTH = CNT_W'(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] din_q;
  logic             dir_q, rotate_q, fill_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] ctr_q;
  logic [CNT_W-1:0] w_count_clamped;

  assign w_count_clamped = (count > C_WIDTH) ? C_WIDTH : count;

  // State register
  always_ff @(posedge CLK) begin
    if (!CLRb) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Job parameters are captured once on acceptance; later input changes
  // have no effect on the running job.
  always_ff @(posedge CLK) begin
    if (!CLRb) begin
      din_q    <= '0;
      dir_q    <= 1'b0;
      rotate_q <= 1'b0;
      fill_q   <= 1'b0;
      cnt_q    <= '0;
      ctr_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            din_q    <= din;
            dir_q    <= dir;
            rotate_q <= rotate;
            fill_q   <= fill_in;
            cnt_q    <= w_count_clamped;
          end
        end
        ST_LOAD:  ctr_q <= cnt_q;
        ST_SHIFT: ctr_q <= ctr_q - 1'b1;
        default:  ;
      endcase
    end
  end

  // Next-state logic. SHIFT exits when the counter shows 1, i.e. on the
  // last of the N shift cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_LOAD;
      ST_LOAD:  state_d = (cnt_q != '0) ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if (ctr_q == {{(CNT_W-1){1'b0}}, 1'b1}) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode. Rotate fill and the serial bit come straight from the
  // register readback so they track the current Q.
  always_comb begin
    s          = 2'b00;
    D          = din_q;
    SDL        = 1'b0;
    SDR        = 1'b0;
    sout       = 1'b0;
    sout_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      ST_LOAD: begin
        s    = 2'b11;
        busy = 1'b1;
      end
      ST_SHIFT: begin
        s          = dir_q ? 2'b10 : 2'b01;
        busy       = 1'b1;
        SDL        = rotate_q ? q_in[WIDTH-1] : fill_q;
        SDR        = rotate_q ? q_in[0] : fill_q;
        sout       = dir_q ? q_in[WIDTH-1] : q_in[0];
        sout_valid = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire
